// File: rtl/motor3_commutation_ctrl.sv
// motor3_commutation_ctrl: six-step commutation sequencer with high-side PWM,
// per-phase dead-time and optional low-side brake (enabled by MOTOR3_BRAKE_EN).
// Ports: clkI/nRstI clock and async active-low reset; enableI run enable;
// dirI 1=forward 0=reverse; dutyI high-side on-count per PWM period;
// stepPeriodI cycles per step (0 holds); brakeI brake request;
// ph{A,B,C}_down1_up2o phase commands (0 off, 1 low, 2 high);
// stepO current step 0..5; stepStrobeO one-cycle pulse per step change.
module motor3_commutation_ctrl #(
  parameter int DEAD_CYC  = 8,
  parameter int PWM_BITS  = 8,
  parameter int STEP_BITS = 16
) (
  input  logic                 clkI,
  input  logic                 nRstI,
  input  logic                 enableI,
  input  logic                 dirI,
  input  logic [PWM_BITS-1:0]  dutyI,
  input  logic [STEP_BITS-1:0] stepPeriodI,
  input  logic                 brakeI,
  output logic [1:0]           phA_down1_up2o,
  output logic [1:0]           phB_down1_up2o,
  output logic [1:0]           phC_down1_up2o,
  output logic [2:0]           stepO,
  output logic                 stepStrobeO
);
  localparam int IW = $clog2(DEAD_CYC + 2);
  localparam logic [IW-1:0] DEAD = IW'(DEAD_CYC);

  logic                 brake;
`ifdef MOTOR3_BRAKE_EN
  assign brake = brakeI;
`else
  logic unused_brake;
  assign unused_brake = brakeI;
  assign brake = 1'b0;
`endif

  logic [STEP_BITS-1:0]   step_cnt_q, step_cnt_d;
  logic [2:0]             step_q, step_d, step_nxt;
  logic                   strobe_q, strobe_d, run, tc, pwm_on;
  logic [PWM_BITS-1:0]    pwm_cnt_q, pwm_cnt_d, duty_q, duty_d;
  logic [2:0][1:0]        row, tgt, out_q, out_d, last_q, last_d;
  logic [2:0][IW-1:0]     idle_q, idle_d;

  // Table row packed as {C,B,A} so row[p] indexes phase p directly.
  function automatic logic [2:0][1:0] row_of(input logic [2:0] s);
    case (s)
      3'd0:    row_of = {2'd0, 2'd1, 2'd2};
      3'd1:    row_of = {2'd1, 2'd0, 2'd2};
      3'd2:    row_of = {2'd1, 2'd2, 2'd0};
      3'd3:    row_of = {2'd0, 2'd2, 2'd1};
      3'd4:    row_of = {2'd2, 2'd0, 2'd1};
      3'd5:    row_of = {2'd2, 2'd1, 2'd0};
      default: row_of = '0;
    endcase
  endfunction

  // >= rather than == so a period shrinking below the count advances next cycle.
  assign run        = enableI && |stepPeriodI && !brake;
  assign tc         = step_cnt_q >= stepPeriodI - STEP_BITS'(1);
  assign step_nxt   = dirI ? (step_q == 3'd5 ? 3'd0 : step_q + 3'd1)
                           : (step_q == 3'd0 ? 3'd5 : step_q - 3'd1);
  assign step_cnt_d = run ? (tc ? '0 : step_cnt_q + STEP_BITS'(1)) : step_cnt_q;
  assign step_d     = run && tc ? step_nxt : step_q;
  assign strobe_d   = run && tc;

  assign pwm_cnt_d  = enableI ? pwm_cnt_q + PWM_BITS'(1) : '0;
  assign duty_d     = &pwm_cnt_q ? dutyI : duty_q;
  assign pwm_on     = pwm_cnt_q < duty_q;
  assign row        = row_of(step_q);

  // A phase may only switch between low and high side after DEAD idle cycles;
  // returning to the same side (PWM chopping) is immediate.
  always_comb begin
    tgt    = '0;
    out_d  = '0;
    last_d = last_q;
    idle_d = idle_q;
    for (int p = 0; p < 3; p++) begin
      tgt[p]    = brake ? 2'd1 : ((!enableI || (row[p] == 2'd2 && !pwm_on)) ? 2'd0 : row[p]);
      out_d[p]  = (tgt[p] == 2'd0 || tgt[p] == last_q[p] || idle_q[p] >= DEAD) ? tgt[p] : 2'd0;
      last_d[p] = out_d[p] != 2'd0 ? out_d[p] : last_q[p];
      idle_d[p] = out_d[p] != 2'd0 ? '0 : (idle_q[p] >= DEAD ? DEAD : idle_q[p] + IW'(1));
    end
  end

  always_ff @(posedge clkI or negedge nRstI)
    if (!nRstI) begin
      step_cnt_q <= '0;
      step_q     <= '0;
      strobe_q   <= 1'b0;
      pwm_cnt_q  <= '0;
      duty_q     <= '0;
      out_q      <= '0;
      last_q     <= '0;
      idle_q     <= '0;
    end else begin
      step_cnt_q <= step_cnt_d;
      step_q     <= step_d;
      strobe_q   <= strobe_d;
      pwm_cnt_q  <= pwm_cnt_d;
      duty_q     <= duty_d;
      out_q      <= out_d;
      last_q     <= last_d;
      idle_q     <= idle_d;
    end

  assign phA_down1_up2o = out_q[0];
  assign phB_down1_up2o = out_q[1];
  assign phC_down1_up2o = out_q[2];
  assign stepO          = step_q;
  assign stepStrobeO    = strobe_q;
endmodule

// File: tb/tb_motor3_commutation_ctrl.sv
// tb_motor3_commutation_ctrl: scoreboard bench with a cycle-level reference model.
module tb_motor3_commutation_ctrl;
  localparam int DC = 4;
  localparam int PB = 8;
  localparam int SB = 16;
  localparam int PMAX = (1 << PB) - 1;

  logic          clkI = 1'b0;
  logic          nRstI = 1'b0;
  logic          enableI = 1'b0;
  logic          dirI = 1'b1;
  logic [PB-1:0] dutyI = '0;
  logic [SB-1:0] stepPeriodI = '0;
  logic          brakeI = 1'b0;
  logic [1:0]    pa, pb, pc;
  logic [2:0]    stepO;
  logic          stepStrobeO;

  motor3_commutation_ctrl #(.DEAD_CYC(DC), .PWM_BITS(PB), .STEP_BITS(SB)) dut (
    .clkI(clkI), .nRstI(nRstI), .enableI(enableI), .dirI(dirI), .dutyI(dutyI),
    .stepPeriodI(stepPeriodI), .brakeI(brakeI),
    .phA_down1_up2o(pa), .phB_down1_up2o(pb), .phC_down1_up2o(pc),
    .stepO(stepO), .stepStrobeO(stepStrobeO)
  );

  always #5 clkI = ~clkI;

  typedef struct { int ph[3]; int step; int strobe; } exp_t;
  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: six-step table, a step age, a PWM phase, and per-phase
  // memory of the last driven side plus the length of the current zero run.
  int tbl[6][3] = '{'{2,1,0}, '{2,0,1}, '{0,2,1}, '{1,2,0}, '{1,0,2}, '{0,1,2}};
  int m_step, m_age, m_pwm, m_duty;
  int m_last[3], m_zrun[3];

  always @(posedge clkI or negedge nRstI) begin : model
    exp_t e;
    int t, o;
    bit brk;
    if (!nRstI) begin
      m_step = 0; m_age = 0; m_pwm = 0; m_duty = 0;
      for (int p = 0; p < 3; p++) begin m_last[p] = 0; m_zrun[p] = 0; end
      exp_q.delete();
    end else begin
`ifdef MOTOR3_BRAKE_EN
      brk = brakeI;
`else
      brk = 1'b0;
`endif
      for (int p = 0; p < 3; p++) begin
        if (brk) t = 1;
        else if (!enableI) t = 0;
        else t = (tbl[m_step][p] == 2 && !(m_pwm < m_duty)) ? 0 : tbl[m_step][p];
        o = (t == 0 || t == m_last[p] || m_zrun[p] >= DC) ? t : 0;
        if (o != 0) begin m_last[p] = o; m_zrun[p] = 0; end
        else m_zrun[p]++;
        e.ph[p] = o;
      end
      e.strobe = 0;
      if (enableI && stepPeriodI != 0 && !brk) begin
        if (m_age + 1 >= int'(stepPeriodI)) begin
          m_age = 0;
          m_step = (m_step + (dirI ? 1 : 5)) % 6;
          e.strobe = 1;
        end else m_age++;
      end
      if (m_pwm == PMAX) m_duty = int'(dutyI);
      m_pwm = enableI ? (m_pwm + 1) % (PMAX + 1) : 0;
      e.step = m_step;
      exp_q.push_back(e);
    end
  end

  // Monitor: pops one expectation per presented output cycle; also checks the
  // reversal gap directly on the observed waveform, independent of the model.
  int r_last[3] = '{0, 0, 0};
  int r_zeros[3] = '{0, 0, 0};
  always @(negedge clkI) begin : monitor
    exp_t e;
    int act[3];
    if (nRstI && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act[0] = int'(pa); act[1] = int'(pb); act[2] = int'(pc);
      chk("phA", act[0], e.ph[0]);
      chk("phB", act[1], e.ph[1]);
      chk("phC", act[2], e.ph[2]);
      chk("step", int'(stepO), e.step);
      chk("strobe", int'(stepStrobeO), e.strobe);
      for (int p = 0; p < 3; p++) begin
        if (act[p] == 3) chk("code3", act[p], 0);
        if (act[p] != 0) begin
          if (r_last[p] != 0 && r_last[p] != act[p]) begin
            n_checks++;
            if (r_zeros[p] < DC) begin
              n_fail++;
              $display("FAIL deadtime ph%0d: got %0d zero cycles, required >= %0d", p, r_zeros[p], DC);
            end
          end
          r_last[p] = act[p];
          r_zeros[p] = 0;
        end else r_zeros[p]++;
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clkI);
  endtask

  initial begin
    run(3);
    chk("rst_a", int'(pa), 0);
    chk("rst_b", int'(pb), 0);
    chk("rst_c", int'(pc), 0);
    chk("rst_step", int'(stepO), 0);
    chk("rst_strobe", int'(stepStrobeO), 0);
    enableI = 1'b1; stepPeriodI = 100; dutyI = 255; dirI = 1'b1;
    nRstI = 1'b1;
    run(5);
    chk("post_rst_b", int'(pb), 1);
    run(700);
    dirI = 1'b0;
    run(300);
    stepPeriodI = 0; dutyI = 64;
    run(600);
    run(100);
    dutyI = 200;
    run(600);
    stepPeriodI = 7;
    for (int i = 0; i < 25; i++) begin
      dirI = ~dirI;
      run(13);
    end
    stepPeriodI = 50; dirI = 1'b1;
    run(80);
    stepPeriodI = 3;
    run(20);
`ifdef MOTOR3_BRAKE_EN
    stepPeriodI = 100;
    brakeI = 1'b1;
    run(120);
    brakeI = 1'b0;
    run(120);
`endif
    for (int s = 0; s < 100; s++) begin
      enableI = $urandom_range(0, 9) != 0;
      dirI = $urandom_range(0, 1) == 1;
      dutyI = PB'($urandom_range(0, PMAX));
      stepPeriodI = $urandom_range(0, 4) == 0 ? '0 : SB'($urandom_range(1, 60));
      brakeI = $urandom_range(0, 7) == 0;
      run($urandom_range(20, 200));
    end
    brakeI = 1'b0; enableI = 1'b1; stepPeriodI = 10; dutyI = 255;
    run(300);
    #2 nRstI = 1'b0;
    #1;
    chk("async_rst_a", int'(pa), 0);
    chk("async_rst_b", int'(pb), 0);
    chk("async_rst_c", int'(pc), 0);
    chk("async_rst_step", int'(stepO), 0);
    run(3);
    for (int p = 0; p < 3; p++) begin r_last[p] = 0; r_zeros[p] = 0; end
    nRstI = 1'b1;
    run(400);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
